// File: rtl/vga_pic_sequencer_pkg.sv
// Shared definitions for the VGA picture sequencer: display timing totals,
// the sequencer mode encoding and the fixed picture descriptor table.
package vga_pic_pkg;

    localparam int H_TOTAL  = 1056;
    localparam int V_TOTAL  = 628;
    localparam int MAX_PICS = 4;

    typedef enum logic {
        MANUAL = 1'b0,
        SLIDE  = 1'b1
    } mode_e;

    typedef struct packed {
        logic [15:0] base;
        logic [9:0]  width;
        logic [9:0]  height;
        logic [3:0]  scale;
    } pic_desc_t;

    // Entry 2 reuses the small image at base 0, replicated 10x to fill the screen.
    function automatic pic_desc_t pic_lookup(input logic [1:0] idx);
        pic_desc_t desc;
        case (idx)
            2'd0:    desc = '{base: 16'd0,     width: 10'd80,  height: 10'd60,  scale: 4'd1};
            2'd1:    desc = '{base: 16'd4800,  width: 10'd220, height: 10'd180, scale: 4'd1};
            2'd2:    desc = '{base: 16'd0,     width: 10'd80,  height: 10'd60,  scale: 4'd10};
            default: desc = '{base: 16'd44400, width: 10'd110, height: 10'd90,  scale: 4'd1};
        endcase
        return desc;
    endfunction

endpackage

// File: rtl/vga_pic_sequencer_key_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and a
// one-cycle press pulse on every accepted 1->0 transition of the level.
module key_debounce
    import vga_pic_pkg::*;
#(
    parameter int DEB_CNT = 400000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o
);

    localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DEB_CNT - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == LAST_CNT) begin
                level_d = ~level_q;
                press_d = level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Released (1) is the idle level for both the synchronizer and the output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/vga_pic_sequencer.sv
// Picture-selection controller: manual stepping or timed slideshow, with the
// active descriptor committed only on frame boundaries to avoid tearing.
module vga_pic_sequencer
    import vga_pic_pkg::*;
#(
    parameter int DEB_CNT      = 400000,
    parameter int SLIDE_FRAMES = 120,
    parameter int NUM_PICS     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        key_next_n_i,
    input  logic        key_mode_n_i,
    input  logic        frame_start_i,
    output logic [1:0]  pic_sel_o,
    output logic [15:0] pic_base_o,
    output logic [9:0]  pic_w_o,
    output logic [9:0]  pic_h_o,
    output logic [3:0]  pic_scale_o,
    output logic        cfg_update_o,
    output logic        slide_on_o
);

    localparam int FCW = (SLIDE_FRAMES > 1) ? $clog2(SLIDE_FRAMES) : 1;
    localparam logic [FCW-1:0] LAST_FRAME = FCW'(SLIDE_FRAMES - 1);
    localparam logic [1:0]     LAST_IDX   = 2'(NUM_PICS - 1);

    function automatic logic [1:0] nextIdx(input logic [1:0] idx);
        return (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
    endfunction

    logic nextPress, modePress;
    logic nextLevel, modeLevel;
    logic levels_unused;

    mode_e          mode_q, mode_d;
    logic [1:0]     pendingIdx_q, pendingIdx_d;
    logic [1:0]     activeIdx_q, activeIdx_d;
    logic [FCW-1:0] frameCnt_q, frameCnt_d;
    logic           slideOn_q, slideOn_d;
    logic           cfgUpdate_q, cfgUpdate_d;
    logic [1:0]     picSel_q;
    pic_desc_t      picDesc_q, picDesc_d;

    key_debounce #(.DEB_CNT(DEB_CNT)) u_keyNext (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .key_n_i (key_next_n_i),
        .level_o (nextLevel),
        .press_o (nextPress)
    );

    key_debounce #(.DEB_CNT(DEB_CNT)) u_keyMode (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .key_n_i (key_mode_n_i),
        .level_o (modeLevel),
        .press_o (modePress)
    );

    assign levels_unused = nextLevel ^ modeLevel;

    // Mode register.
    always_ff @(posedge clk_i) begin
        if (rst_i) mode_q <= MANUAL;
        else       mode_q <= mode_d;
    end

    // Frame action of the current mode is resolved first; a mode press then overrides.
    always_comb begin
        mode_d       = mode_q;
        pendingIdx_d = pendingIdx_q;
        activeIdx_d  = activeIdx_q;
        frameCnt_d   = frameCnt_q;
        case (mode_q)
            MANUAL: begin
                if (frame_start_i) activeIdx_d = pendingIdx_q;
                if (nextPress)     pendingIdx_d = nextIdx(pendingIdx_q);
                if (modePress) begin
                    mode_d     = SLIDE;
                    frameCnt_d = '0;
                end
            end
            default: begin
                if (frame_start_i) begin
                    if (frameCnt_q == LAST_FRAME) begin
                        frameCnt_d   = '0;
                        activeIdx_d  = nextIdx(activeIdx_q);
                        pendingIdx_d = nextIdx(activeIdx_q);
                    end else begin
                        frameCnt_d = frameCnt_q + FCW'(1);
                    end
                end
                if (modePress) begin
                    mode_d       = MANUAL;
                    pendingIdx_d = activeIdx_d;
                    frameCnt_d   = '0;
                end
            end
        endcase
    end

    // Descriptor lookup lags the index by one cycle; a pulse marks a real change.
    always_comb begin
        slideOn_d   = (mode_q == SLIDE);
        picDesc_d   = pic_lookup(activeIdx_q);
        cfgUpdate_d = (activeIdx_q != picSel_q);
    end

    // Selection state and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pendingIdx_q <= 2'd0;
            activeIdx_q  <= 2'd0;
            frameCnt_q   <= '0;
            slideOn_q    <= 1'b0;
            cfgUpdate_q  <= 1'b0;
            picSel_q     <= 2'd0;
            picDesc_q    <= pic_lookup(2'd0);
        end else begin
            pendingIdx_q <= pendingIdx_d;
            activeIdx_q  <= activeIdx_d;
            frameCnt_q   <= frameCnt_d;
            slideOn_q    <= slideOn_d;
            cfgUpdate_q  <= cfgUpdate_d;
            picSel_q     <= activeIdx_q;
            picDesc_q    <= picDesc_d;
        end
    end

    assign pic_sel_o    = picSel_q;
    assign pic_base_o   = picDesc_q.base;
    assign pic_w_o      = picDesc_q.width;
    assign pic_h_o      = picDesc_q.height;
    assign pic_scale_o  = picDesc_q.scale;
    assign cfg_update_o = cfgUpdate_q;
    assign slide_on_o   = slideOn_q;

endmodule

// File: tb/tb_vga_pic_sequencer.sv
// Directed bench for the picture sequencer with short debounce and slideshow periods.
module tb_vga_pic_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        keyNextN = 1'b1;
    logic        keyModeN = 1'b1;
    logic        frameStart = 1'b0;
    logic [1:0]  picSel;
    logic [15:0] picBase;
    logic [9:0]  picW;
    logic [9:0]  picH;
    logic [3:0]  picScale;
    logic        cfgUpdate;
    logic        slideOn;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    int expBase  [4] = '{0, 4800, 0, 44400};
    int expW     [4] = '{80, 220, 80, 110};
    int expH     [4] = '{60, 180, 60, 90};
    int expScale [4] = '{1, 1, 10, 1};

    vga_pic_sequencer #(
        .DEB_CNT      (8),
        .SLIDE_FRAMES (3),
        .NUM_PICS     (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .key_next_n_i  (keyNextN),
        .key_mode_n_i  (keyModeN),
        .frame_start_i (frameStart),
        .pic_sel_o     (picSel),
        .pic_base_o    (picBase),
        .pic_w_o       (picW),
        .pic_h_o       (picH),
        .pic_scale_o   (picScale),
        .cfg_update_o  (cfgUpdate),
        .slide_on_o    (slideOn)
    );

    // Free-running pixel clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkPic(input string tag, input int idx);
        checkOutput({tag, "_sel"},   32'(picSel),   32'(idx));
        checkOutput({tag, "_base"},  32'(picBase),  32'(expBase[idx]));
        checkOutput({tag, "_w"},     32'(picW),     32'(expW[idx]));
        checkOutput({tag, "_h"},     32'(picH),     32'(expH[idx]));
        checkOutput({tag, "_scale"}, 32'(picScale), 32'(expScale[idx]));
    endtask

    // which: 0 = next key, 1 = mode key
    task automatic applyStimulus(input int which, input int lowCycles, input int highCycles);
        if (which == 0) keyNextN = 1'b0; else keyModeN = 1'b0;
        ticks(lowCycles);
        keyNextN = 1'b1;
        keyModeN = 1'b1;
        ticks(highCycles);
    endtask

    task automatic runFrame(input string tag, input int expSel, input logic expCfg);
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        checkOutput({tag, "_cfgEarly"}, 32'(cfgUpdate), 32'd0);
        tick();
        checkOutput({tag, "_cfg"}, 32'(cfgUpdate), 32'(expCfg));
        checkPic(tag, expSel);
        tick();
        checkOutput({tag, "_cfgDone"}, 32'(cfgUpdate), 32'd0);
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        ticks(n);
        rst = 1'b0;
    endtask

    initial begin
        ticks(2);

        // Reset values
        doReset(3);
        checkPic("reset", 0);
        checkOutput("reset_cfg",   32'(cfgUpdate), 32'd0);
        checkOutput("reset_slide", 32'(slideOn),   32'd0);

        // Short glitch is rejected, long press is accepted
        applyStimulus(0, 5, 15);
        runFrame("glitch", 0, 1'b0);
        applyStimulus(0, 20, 12);
        runFrame("deb20", 1, 1'b1);

        // Accumulate within a frame and wrap modulo 4
        doReset(3);
        applyStimulus(0, 12, 12);
        applyStimulus(0, 12, 12);
        applyStimulus(0, 12, 12);
        runFrame("accum3", 3, 1'b1);
        applyStimulus(0, 12, 12);
        applyStimulus(0, 12, 12);
        runFrame("wrap", 1, 1'b1);

        // Press event coincides with frame_start: commit uses old pending
        doReset(3);
        keyNextN = 1'b0;
        ticks(10);
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        checkOutput("coll_cfgEarly", 32'(cfgUpdate), 32'd0);
        tick();
        checkOutput("coll_cfg", 32'(cfgUpdate), 32'd0);
        checkOutput("coll_sel", 32'(picSel),    32'd0);
        ticks(2);
        keyNextN = 1'b1;
        ticks(12);
        runFrame("collNext", 1, 1'b1);

        // Slideshow advances every third frame, next presses ignored
        doReset(3);
        applyStimulus(1, 12, 12);
        checkOutput("slide_on", 32'(slideOn), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            runFrame("slideHoldA", (k - 1) % 4, 1'b0);
            if (k == 1) applyStimulus(0, 12, 12);
            runFrame("slideHoldB", (k - 1) % 4, 1'b0);
            runFrame("slideStep", k % 4, 1'b1);
        end

        // Back to manual, selection holds
        applyStimulus(1, 12, 12);
        checkOutput("slide_off", 32'(slideOn), 32'd0);
        checkOutput("slide_off_sel", 32'(picSel), 32'd0);
        runFrame("manualAgain", 0, 1'b0);

        // Reset discards pending presses
        applyStimulus(0, 12, 12);
        applyStimulus(0, 12, 12);
        doReset(1);
        runFrame("rstPend", 0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/vga_pic_sequencer.md
Name: vga_pic_sequencer

Overview:
- Picture-selection controller for the 800x600 VGA display path (1056x628 total timing, ~40 MHz pixel clock).
- Debounces two raw push-buttons and keeps manual or slideshow mode.
- Publishes the active image descriptor (ROM base address, width, height, scale) to the display engine.
- Descriptor changes only at frame boundaries, so no image tears mid-frame.

Parameters:
- DEB_CNT, 400000: consecutive stable clk cycles before a key level is accepted (10 ms at 40 MHz).
- SLIDE_FRAMES, 120: frames each picture is shown in slideshow mode.
- NUM_PICS, 4: number of entries in the picture table (max 4).

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- key_next_n  in  1  raw button, active-low, asynchronous to clk: advance picture
- key_mode_n  in  1  raw button, active-low, asynchronous to clk: toggle manual/slideshow
- frame_start  in  1  one-cycle pulse from timing generator at hs_counter==1055 && vs_counter==627
- pic_sel  out  2  index of the displayed picture
- pic_base  out  16  ROM word address of pixel (0,0)
- pic_w  out  10  picture width, pixels
- pic_h  out  10  picture height, lines
- pic_scale  out  4  pixel replication factor (1 or 10)
- cfg_update  out  1  one-cycle pulse: pic_* just changed
- slide_on  out  1  1 = slideshow mode

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - mode MANUAL, active_idx=0, pending_idx=0, frame counter 0, slide_on=0, cfg_update=0.
  - pic_* = entry 0: base 0, w 80, h 60, scale 1.
  - Debounced levels = 1 (released); synchronizers = 1.
- Reset mid-operation discards any pending selection and any partial debounce count.
- Key path, identical for each key:
  - 2-flop synchronizer, then a counter that runs while the synchronized level differs from the debounced level.
  - Counter clears on any agreement.
  - On reaching DEB_CNT-1 the debounced level flips.
  - Press event = debounced 1->0, one cycle wide. Release produces no event.
  - A glitch shorter than DEB_CNT cycles produces no event.
- Picture table (shared package):
  - 0: base 0, 80x60, scale 1.
  - 1: base 4800, 220x180, scale 1.
  - 2: base 0, 80x60, scale 10 (fullscreen).
  - 3: base 44400, 110x90, scale 1.
- MANUAL state:
  - next press: pending_idx <= (pending_idx+1) mod NUM_PICS. Multiple presses within a frame accumulate.
  - frame_start: active_idx <= pending_idx.
  - Press and frame_start in the same cycle: commit uses the old pending_idx; the press lands in pending_idx for the next frame.
  - mode press: go to SLIDE, frame counter <= 0.
- SLIDE state:
  - Every frame_start increments the frame counter.
  - When frame_start arrives with counter==SLIDE_FRAMES-1: counter <= 0, active_idx <= (active_idx+1) mod NUM_PICS, pending_idx <= same value.
  - next presses are ignored.
  - mode press: go to MANUAL, pending_idx <= active_idx, counter <= 0.
  - mode press and frame_start in the same cycle: the frame_start action for the current state executes first, then the mode switch applies.
- slide_on is registered, 1 in SLIDE, updated the cycle after the transition edge.
- Output latency:
  - Cycle N: frame_start=1. Edge closing N loads active_idx.
  - Edge closing N+1 registers the table lookup into pic_*.
  - Cycle N+2: new pic_* valid and cfg_update=1 for exactly one cycle.
  - cfg_update fires only if active_idx actually changed; no pulse when the committed index equals the old one.
- Width rules: all index arithmetic is 2-bit modulo NUM_PICS (explicit wrap when NUM_PICS<4). Frame counter is clog2(SLIDE_FRAMES) bits and saturates nothing (it wraps via compare). Debounce counter is clog2(DEB_CNT) bits.
- pic_* hold steady between cfg_update pulses.

Decomposition:
- Package vga_pic_pkg:
  - Picture-table constants (base/w/h/scale per index).
  - Mode enum {MANUAL, SLIDE}.
  - H_TOTAL=1056, V_TOTAL=628.
- Sub-module key_debounce (params DEB_CNT; ports clk, rst, key_n, level, press), instantiated twice.
- Main FSM and table lookup stay in vga_pic_sequencer.

Test Plan:
- Reset: assert rst 3 cycles -> pic_sel=0, pic_base=0, pic_w=80, pic_h=60, pic_scale=1, cfg_update=0, slide_on=0.
- Debounce (DEB_CNT=8):
  - key_next_n low for 5 cycles then high -> no change after following frame_start.
  - Low for 20 cycles, then frame_start -> pic_sel=1, pic_base=4800, pic_w=220, pic_h=180; cfg_update pulses exactly 2 cycles after frame_start.
- Accumulate and wrap:
  - 3 clean next presses within one frame, then frame_start -> pic_sel=3, base 44400, 110x90.
  - 2 more presses, then frame_start -> pic_sel=1.
- Collision: press event in same cycle as frame_start (pending 0) -> pic_sel stays 0, no cfg_update; next frame_start -> pic_sel=1.
- Slideshow (SLIDE_FRAMES=3):
  - Mode press -> slide_on=1; pic_sel advances every 3rd frame_start: 0,1,2 (scale 10),3,0.
  - next presses during SLIDE have no effect.
  - Mode press -> slide_on=0 and pic_sel holds.
- Reset mid-pending: 2 presses, rst pulse before frame_start -> after frame_start pic_sel=0, no cfg_update.
